// File: rtl/uart_tx_stream_mux.sv
// uart_tx_stream_mux: per-channel byte FIFOs drained one byte at a time by an
// arbiter into the start/busy handshake of a UART transmitter.
module uart_tx_stream_mux #(
   parameter int NUM_CHANNELS = 2,
   parameter int DATA_WIDTH   = 8,
   parameter int FIFO_DEPTH   = 16,
   parameter int ARB_MODE     = 0,
   parameter int ACK_TIMEOUT  = 4
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic [NUM_CHANNELS-1:0]                      chValid,
   input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]           chData,
   output logic [NUM_CHANNELS-1:0]                      chReady,
   output logic [NUM_CHANNELS-1:0]                      overflow,
   input  logic                                         clearOverflow,
   output logic                                         txStart,
   output logic [DATA_WIDTH-1:0]                        txData,
   input  logic                                         txBusy,
   output logic [$clog2(NUM_CHANNELS*FIFO_DEPTH+1)-1:0] pendingCount
);

   localparam int PTR_W = $clog2(FIFO_DEPTH) + 1;
   localparam int ADR_W = PTR_W - 1;
   localparam int CNT_W = $clog2(NUM_CHANNELS*FIFO_DEPTH+1);
   localparam int CH_W  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
   localparam int TMR_W = $clog2(ACK_TIMEOUT+1);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_ACK  = 2'd1,
      ST_WAIT_DONE = 2'd2
   } state_t;

   state_t                  state_r;
   logic [DATA_WIDTH-1:0]   mem_r     [NUM_CHANNELS][FIFO_DEPTH];
   logic [PTR_W-1:0]        wr_ptr_r  [NUM_CHANNELS];
   logic [PTR_W-1:0]        rd_ptr_r  [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0] ready_r;
   logic [NUM_CHANNELS-1:0] ovf_r;
   logic [CNT_W-1:0]        pend_r;
   logic                    tx_start_r;
   logic [DATA_WIDTH-1:0]   tx_data_r;
   logic [TMR_W-1:0]        tmr_r;
   logic [CH_W-1:0]         rr_ptr_r;

   logic [NUM_CHANNELS-1:0] full_s;
   logic [NUM_CHANNELS-1:0] empty_s;
   logic [NUM_CHANNELS-1:0] push_s;
   logic [NUM_CHANNELS-1:0] pop_s;
   logic [NUM_CHANNELS-1:0] ready_next_s;
   logic [NUM_CHANNELS-1:0] ovf_next_s;
   logic [PTR_W-1:0]        wr_next_s  [NUM_CHANNELS];
   logic [PTR_W-1:0]        rd_next_s  [NUM_CHANNELS];
   logic [PTR_W-1:0]        cnt_next_s [NUM_CHANNELS];
   logic [CNT_W-1:0]        pend_next_s;
   logic                    grant_s;
   logic [CH_W-1:0]         grant_idx_s;
   logic [DATA_WIDTH-1:0]   head_s;

   // First set bit of mask, scanning upward from start with wrap-around.
   function automatic logic [CH_W-1:0] first_set(input logic [NUM_CHANNELS-1:0] mask,
                                                 input int start);
      logic [CH_W-1:0] idx;
      logic            found;
      int              c;
      idx   = {CH_W{1'b0}};
      found = 1'b0;
      for (int k = 0; k < NUM_CHANNELS; k++) begin
         c     = (start + k) % NUM_CHANNELS;
         idx   = (mask[c] && !found) ? CH_W'(c) : idx;
         found = found | mask[c];
      end
      return idx;
   endfunction

   // FIFO status, arbitration and next-state values for pointers and flags.
   always_comb begin
      full_s       = {NUM_CHANNELS{1'b0}};
      empty_s      = {NUM_CHANNELS{1'b0}};
      push_s       = {NUM_CHANNELS{1'b0}};
      pop_s        = {NUM_CHANNELS{1'b0}};
      ready_next_s = {NUM_CHANNELS{1'b0}};
      ovf_next_s   = {NUM_CHANNELS{1'b0}};
      pend_next_s  = {CNT_W{1'b0}};
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         wr_next_s[i]  = wr_ptr_r[i];
         rd_next_s[i]  = rd_ptr_r[i];
         cnt_next_s[i] = {PTR_W{1'b0}};
         empty_s[i]    = (wr_ptr_r[i] == rd_ptr_r[i]);
         full_s[i]     = (wr_ptr_r[i][PTR_W-1] != rd_ptr_r[i][PTR_W-1]) &&
                         (wr_ptr_r[i][ADR_W-1:0] == rd_ptr_r[i][ADR_W-1:0]);
      end
      grant_idx_s = first_set(~empty_s, (ARB_MODE == 32'sd1) ?
                                        (int'(rr_ptr_r) + 32'sd1) : 32'sd0);
      grant_s     = (state_r == ST_IDLE) && !txBusy && !(&empty_s);
      head_s      = mem_r[grant_idx_s][rd_ptr_r[grant_idx_s][ADR_W-1:0]];
      // A full FIFO refuses the push even when it is being popped this cycle.
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         push_s[i]       = chValid[i] & ~full_s[i];
         pop_s[i]        = grant_s && (grant_idx_s == CH_W'(i));
         wr_next_s[i]    = wr_ptr_r[i] + PTR_W'(push_s[i]);
         rd_next_s[i]    = rd_ptr_r[i] + PTR_W'(pop_s[i]);
         cnt_next_s[i]   = wr_next_s[i] - rd_next_s[i];
         ready_next_s[i] = (cnt_next_s[i] != PTR_W'(FIFO_DEPTH));
         ovf_next_s[i]   = (chValid[i] & full_s[i]) | (ovf_r[i] & ~clearOverflow);
         pend_next_s     = pend_next_s + CNT_W'(cnt_next_s[i]);
      end
   end

   // FIFO storage; entries are qualified by the pointers so need no reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         if (push_s[i]) begin
            mem_r[i][wr_ptr_r[i][ADR_W-1:0]] <= chData[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // FIFO pointers, per-channel status flags and the pending byte total.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            wr_ptr_r[i] <= {PTR_W{1'b0}};
            rd_ptr_r[i] <= {PTR_W{1'b0}};
         end
         ready_r <= {NUM_CHANNELS{1'b1}};
         ovf_r   <= {NUM_CHANNELS{1'b0}};
         pend_r  <= {CNT_W{1'b0}};
      end else begin
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            wr_ptr_r[i] <= wr_next_s[i];
            rd_ptr_r[i] <= rd_next_s[i];
         end
         ready_r <= ready_next_s;
         ovf_r   <= ovf_next_s;
         pend_r  <= pend_next_s;
      end
   end

   // Handshake FSM: grants a byte from IDLE, then follows the busy window.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r    <= ST_IDLE;
         tx_start_r <= 1'b0;
         tx_data_r  <= {DATA_WIDTH{1'b0}};
         tmr_r      <= {TMR_W{1'b0}};
         rr_ptr_r   <= {CH_W{1'b0}};
      end else begin
         tx_start_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (grant_s) begin
                  tx_data_r  <= head_s;
                  tx_start_r <= 1'b1;
                  tmr_r      <= {TMR_W{1'b0}};
                  rr_ptr_r   <= grant_idx_s;
                  state_r    <= ST_WAIT_ACK;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_WAIT_ACK: begin
               // A transmitter that never acknowledges still releases the arbiter.
               if (txBusy) begin
                  state_r <= ST_WAIT_DONE;
               end else if (tmr_r == TMR_W'(ACK_TIMEOUT - 1)) begin
                  state_r <= ST_IDLE;
               end else begin
                  tmr_r <= tmr_r + TMR_W'(32'd1);
               end
            end
            ST_WAIT_DONE: begin
               if (!txBusy) begin
                  state_r <= ST_IDLE;
               end else begin
                  state_r <= ST_WAIT_DONE;
               end
            end
            default: state_r <= ST_IDLE;
         endcase
      end
   end

   assign chReady      = ready_r;
   assign overflow     = ovf_r;
   assign pendingCount = pend_r;
   assign txStart      = tx_start_r;
   assign txData       = tx_data_r;

endmodule

// File: tb/tb_uart_tx_stream_mux.sv
// Bench for uart_tx_stream_mux: a fixed-priority and a round-robin instance share
// stimulus; each is compared every cycle against a queue-based reference model.
module tb_uart_tx_stream_mux;

   localparam int NC     = 3;
   localparam int DW     = 8;
   localparam int DEPTH  = 16;
   localparam int ACK_TO = 4;
   localparam int PW     = $clog2(NC*DEPTH+1);

   logic          clk = 1'b0;
   logic          rst;
   logic [NC-1:0] ch_valid;
   logic [NC*DW-1:0] ch_data;
   logic          clear_ovf;
   logic          tx_busy  [2];
   logic [NC-1:0] ch_ready [2];
   logic [NC-1:0] ovf      [2];
   logic          tx_start [2];
   logic [DW-1:0] tx_data  [2];
   logic [PW-1:0] pend     [2];

   // reference model state, index d*NC+ch for queues
   logic [DW-1:0] mq [2*NC][$];
   int            phase [2];
   int            ack_cnt [2];
   int            last_grant [2];
   logic          exp_start [2];
   logic [DW-1:0] exp_data [2];
   logic [NC-1:0] m_ovf [2];
   int            u_wait [2];
   int            u_hold [2];
   int            u_never_pct, u_dly_max, u_len_min, u_len_max;
   int            n_vec, n_err, cyc;

   always #5 clk = ~clk;

   uart_tx_stream_mux #(.NUM_CHANNELS(NC), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH),
                        .ARB_MODE(0), .ACK_TIMEOUT(ACK_TO)) u_dut_fixed (
      .clk(clk), .rst(rst), .chValid(ch_valid), .chData(ch_data),
      .chReady(ch_ready[0]), .overflow(ovf[0]), .clearOverflow(clear_ovf),
      .txStart(tx_start[0]), .txData(tx_data[0]), .txBusy(tx_busy[0]),
      .pendingCount(pend[0]));

   uart_tx_stream_mux #(.NUM_CHANNELS(NC), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH),
                        .ARB_MODE(1), .ACK_TIMEOUT(ACK_TO)) u_dut_rr (
      .clk(clk), .rst(rst), .chValid(ch_valid), .chData(ch_data),
      .chReady(ch_ready[1]), .overflow(ovf[1]), .clearOverflow(clear_ovf),
      .txStart(tx_start[1]), .txData(tx_data[1]), .txBusy(tx_busy[1]),
      .pendingCount(pend[1]));

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NC*DW-1:0] lane(input int ch, input logic [DW-1:0] b);
      logic [NC*DW-1:0] v;
      v = {(NC*DW){1'b0}};
      v[ch*DW +: DW] = b;
      return v;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2*NC; k++) mq[k].delete();
      for (int d = 0; d < 2; d++) begin
         phase[d] = 0; ack_cnt[d] = 0; last_grant[d] = 0;
         exp_start[d] = 1'b0; exp_data[d] = {DW{1'b0}}; m_ovf[d] = {NC{1'b0}};
      end
   endtask

   task automatic uart_cfg(input int never_pct, input int dly_max, input int len_min, input int len_max);
      u_never_pct = never_pct; u_dly_max = dly_max; u_len_min = len_min; u_len_max = len_max;
   endtask

   // transmitter model: busy for this cycle from the pending acknowledge/hold counters
   task automatic uart_tick(input int d);
      if (u_hold[d] > 0) begin
         tx_busy[d] = 1'b1;
         u_hold[d]--;
      end else if (u_wait[d] > 0) begin
         u_wait[d]--;
         if (u_wait[d] == 0) begin
            tx_busy[d] = 1'b1;
            u_hold[d]  = int'($urandom_range(u_len_max, u_len_min)) - 1;
         end else begin
            tx_busy[d] = 1'b0;
         end
      end else begin
         tx_busy[d] = 1'b0;
      end
   endtask

   task automatic uart_schedule(input int d);
      if (int'($urandom_range(99, 0)) < u_never_pct) u_wait[d] = 0;
      else u_wait[d] = 1 + int'($urandom_range(u_dly_max, 0));
   endtask

   task automatic check_outputs();
      for (int d = 0; d < 2; d++) begin
         int tot;
         logic [NC-1:0] rdy;
         tot = 0;
         for (int ch = 0; ch < NC; ch++) begin
            tot += mq[d*NC+ch].size();
            rdy[ch] = (mq[d*NC+ch].size() < DEPTH);
         end
         check_value($sformatf("d%0d txStart c%0d", d, cyc), 32'(tx_start[d]), 32'(exp_start[d]));
         check_value($sformatf("d%0d txData c%0d", d, cyc), 32'(tx_data[d]), 32'(exp_data[d]));
         check_value($sformatf("d%0d pending c%0d", d, cyc), 32'(pend[d]), 32'(tot));
         check_value($sformatf("d%0d overflow c%0d", d, cyc), 32'(ovf[d]), 32'(m_ovf[d]));
         check_value($sformatf("d%0d chReady c%0d", d, cyc), 32'(ch_ready[d]), 32'(rdy));
         check_value($sformatf("d%0d startWhileBusy c%0d", d, cyc),
                     32'(tx_start[d] & tx_busy[d]), 32'd0);
      end
   endtask

   // what the next clock edge does, from the queue contents at the start of the cycle
   task automatic model_advance(input int d);
      int   pre [NC];
      int   g;
      logic grant;
      grant = 1'b0;
      g = 0;
      for (int ch = 0; ch < NC; ch++) pre[ch] = mq[d*NC+ch].size();
      if (phase[d] == 0 && !tx_busy[d]) begin
         for (int k = 0; k < NC; k++) begin
            int c;
            c = (d == 0) ? k : (last_grant[d] + 1 + k) % NC;
            if (!grant && pre[c] > 0) begin
               grant = 1'b1;
               g = c;
            end
         end
      end
      if (phase[d] == 1) begin
         if (tx_busy[d]) phase[d] = 2;
         else if (ack_cnt[d] == ACK_TO - 1) phase[d] = 0;
         else ack_cnt[d]++;
      end else if (phase[d] == 2) begin
         if (!tx_busy[d]) phase[d] = 0;
      end
      exp_start[d] = grant;
      if (grant) begin
         exp_data[d]   = mq[d*NC+g].pop_front();
         phase[d]      = 1;
         ack_cnt[d]    = 0;
         last_grant[d] = g;
      end
      for (int ch = 0; ch < NC; ch++) begin
         if (ch_valid[ch] && pre[ch] >= DEPTH) m_ovf[d][ch] = 1'b1;
         else if (clear_ovf) m_ovf[d][ch] = 1'b0;
         if (ch_valid[ch] && pre[ch] < DEPTH) mq[d*NC+ch].push_back(ch_data[ch*DW +: DW]);
      end
   endtask

   task automatic run_cycle(input logic [NC-1:0] valid, input logic [NC*DW-1:0] data, input logic clr);
      for (int d = 0; d < 2; d++) uart_tick(d);
      check_outputs();
      for (int d = 0; d < 2; d++) if (exp_start[d]) uart_schedule(d);
      ch_valid  = valid;
      ch_data   = data;
      clear_ovf = clr;
      for (int d = 0; d < 2; d++) model_advance(d);
      cyc++;
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) run_cycle({NC{1'b0}}, {(NC*DW){1'b0}}, 1'b0);
   endtask

   // asynchronous reset asserted mid-cycle; the transmitter keeps its current byte
   task automatic apply_reset();
      for (int d = 0; d < 2; d++) uart_tick(d);
      ch_valid  = {NC{1'b0}};
      clear_ovf = 1'b0;
      rst = 1'b0;
      #1;
      for (int d = 0; d < 2; d++) begin
         check_value($sformatf("d%0d rst txStart", d), 32'(tx_start[d]), 32'd0);
         check_value($sformatf("d%0d rst pending", d), 32'(pend[d]), 32'd0);
         check_value($sformatf("d%0d rst txData", d), 32'(tx_data[d]), 32'd0);
      end
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      cyc++;
   endtask

   initial begin
      n_vec = 0; n_err = 0; cyc = 0;
      rst = 1'b0;
      ch_valid = {NC{1'b0}};
      ch_data = {(NC*DW){1'b0}};
      clear_ovf = 1'b0;
      for (int d = 0; d < 2; d++) begin
         tx_busy[d] = 1'b0; u_wait[d] = 0; u_hold[d] = 0;
      end
      model_reset();
      uart_cfg(0, 0, 10, 10);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // single byte, transmitter busy for 10 cycles
      run_cycle(3'b001, lane(0, 8'h41), 1'b0);
      idle(15);

      // burst of 20 into a 16-deep FIFO, then clear the sticky overflow
      for (int i = 0; i < 20; i++) run_cycle(3'b001, lane(0, DW'(8'h10 + i)), 1'b0);
      idle(240);
      run_cycle({NC{1'b0}}, {(NC*DW){1'b0}}, 1'b1);
      idle(2);

      // two channels loaded together: fixed priority vs alternating grants
      uart_cfg(0, 0, 2, 2);
      for (int i = 0; i < 3; i++)
         run_cycle(3'b011, lane(0, DW'(8'hA0 + i)) | lane(1, DW'(8'hB0 + i)), 1'b0);
      idle(40);

      // transmitter never acknowledges
      uart_cfg(100, 0, 1, 1);
      for (int i = 0; i < 2; i++) run_cycle(3'b100, lane(2, DW'(8'hC0 + i)), 1'b0);
      idle(20);

      // keep pushing ch1 while it is full so a push meets a pop on a full FIFO
      uart_cfg(0, 0, 10, 10);
      for (int i = 0; i < 60; i++) run_cycle(3'b010, lane(1, DW'(i)), 1'b0);
      idle(260);
      run_cycle({NC{1'b0}}, {(NC*DW){1'b0}}, 1'b1);

      // reset while a byte is on the wire and bytes are queued
      for (int i = 0; i < 6; i++) run_cycle(3'b001, lane(0, DW'(8'h60 + i)), 1'b0);
      idle(2);
      apply_reset();
      idle(15);

      // randomized traffic with varying load and occasional reset
      uart_cfg(10, 2, 1, 6);
      for (int seg = 0; seg < 6; seg++) begin
         int pct;
         pct = (seg % 3 == 0) ? 10 : ((seg % 3 == 1) ? 40 : 90);
         for (int i = 0; i < 450; i++) begin
            logic [NC-1:0] v;
            for (int ch = 0; ch < NC; ch++) v[ch] = (int'($urandom_range(99, 0)) < pct);
            if ($urandom_range(399, 0) == 0) apply_reset();
            else run_cycle(v, {(NC*DW){1'b0}} | (NC*DW)'($urandom),
                           ($urandom_range(15, 0) == 0));
         end
      end
      idle(200);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
